// File: rtl/arb4_grant_ctrl_if.sv
// ---------------------------------------------------------------------------
// arb4_grant_ctrl_if
// Bundle between the four requesters and the grant controller.
//   req       [3:0]  level request, one bit per requester
//   done             current owner releases the resource
//   grant     [3:0]  registered one-hot grant (0000 when nobody owns)
//   grant_idx [1:0]  index of current or most recent owner
//   busy             high while a requester owns the resource
//   timeout          one-cycle pulse after a forced release on hold limit
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface arb4_grant_ctrl_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  grant,
        input  grant_idx,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_idx,
        output busy,
        output timeout
    );
endinterface

// File: rtl/arb4_grant_ctrl.sv
// ---------------------------------------------------------------------------
// arb4_grant_ctrl
// Four-requester arbiter driving a one-hot select for one shared resource.
// A winner keeps its grant until it drops its request, asserts done, or
// reaches MAX_HOLD owned cycles. Every release is followed by one IDLE cycle
// with grant=0000 before re-arbitration, so grants never touch.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   synchronous active-low reset
//   bus     arb4_grant_ctrl_if.slave (req, done in; grant, grant_idx,
//           busy, timeout out -- all outputs registered)
//
// Parameters:
//   MAX_HOLD  maximum consecutive owned cycles, 0 = unlimited
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//
// Build option:
//   ARB4_ROUND_ROBIN_EN  defined   -> rotating priority starting after last owner
//                        undefined -> fixed priority, req[0] highest
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | nobody owns; grant=0000; arbitrate on any request
// S_OWN  | grant_idx owns; count hold cycles, release on done/drop/limit
// ---------------------------------------------------------------------------
module arb4_grant_ctrl #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    arb4_grant_ctrl_if.slave  bus
);

    typedef enum logic {S_IDLE, S_OWN} state_t;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [1:0]       idx_q, idx_nxt;
    logic [1:0]       last_idx, last_idx_nxt;
    logic [1:0]       winner;
    logic [3:0]       grant_q, grant_nxt;
    logic             busy_q, busy_nxt;
    logic             timeout_q, timeout_nxt;

`ifdef ARB4_ROUND_ROBIN_EN
    logic [1:0] cand;
    logic       found;

    // Search starts one past the last owner, so it drops to lowest priority.
    always_comb begin
        winner = last_idx + 2'd1;
        cand   = 2'd0;
        found  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = last_idx + 2'(k + 1);
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        winner = 2'd0;
        if (bus.req[0])      winner = 2'd0;
        else if (bus.req[1]) winner = 2'd1;
        else if (bus.req[2]) winner = 2'd2;
        else if (bus.req[3]) winner = 2'd3;
    end
`endif

    // state register (outputs are registered here too)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            hold_cnt  <= '0;
            idx_q     <= 2'd0;
            last_idx  <= 2'd3;
            grant_q   <= 4'b0000;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_cnt_nxt;
            idx_q     <= idx_nxt;
            last_idx  <= last_idx_nxt;
            grant_q   <= grant_nxt;
            busy_q    <= busy_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        idx_nxt      = idx_q;
        last_idx_nxt = last_idx;
        timeout_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (|bus.req) begin
                    state_nxt    = S_OWN;
                    idx_nxt      = winner;
                    last_idx_nxt = winner;
                    hold_cnt_nxt = CNT_W'(1);
                end
            end
            S_OWN: begin
                // A normal release wins over the hold limit: no timeout pulse.
                if (bus.done || !bus.req[idx_q]) begin
                    state_nxt = S_IDLE;
                end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LIM)) begin
                    state_nxt   = S_IDLE;
                    timeout_nxt = 1'b1;
                end else if (hold_cnt != '1) begin
                    // saturate so unlimited hold never wraps
                    hold_cnt_nxt = hold_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // output logic: next values of the registered outputs
    always_comb begin
        busy_nxt  = (state_nxt == S_OWN);
        grant_nxt = busy_nxt ? (4'b0001 << idx_nxt) : 4'b0000;
    end

    assign bus.grant     = grant_q;
    assign bus.grant_idx = idx_q;
    assign bus.busy      = busy_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_arb4_grant_ctrl.sv
// ---------------------------------------------------------------------------
// tb_arb4_grant_ctrl
// Directed stimulus for arb4_grant_ctrl (MAX_HOLD=8). Each step drives one
// cycle of inputs and queues the outputs expected after the next edge; a
// monitor pops and compares on the falling edge of the matching cycle.
// Expected packing: {grant[3:0], grant_idx[1:0], busy, timeout}.
// ---------------------------------------------------------------------------
module tb_arb4_grant_ctrl;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        int         cyc;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t q[$];

    arb4_grant_ctrl_if bus_if ();

    arb4_grant_ctrl #(
        .MAX_HOLD (8),
        .CNT_W    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Drive inputs for the current cycle, expect outputs after the next edge.
    task automatic step(input string name, input logic rst, input logic [3:0] r,
                        input logic d, input logic [3:0] eg, input logic [1:0] ei,
                        input logic eb, input logic et);
        exp_t e;
        rst_n       = rst;
        bus_if.req  = r;
        bus_if.done = d;
        e.cyc  = cyc + 1;
        e.exp  = {eg, ei, eb, et};
        e.name = name;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [7:0] act;
        exp_t       e;
        act = {bus_if.grant, bus_if.grant_idx, bus_if.busy, bus_if.timeout};
        while (q.size() != 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", e.name, e.cyc, cyc);
        end
        if (q.size() != 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s cyc=%0d: got grant=%b idx=%0d busy=%b to=%b, want grant=%b idx=%0d busy=%b to=%b",
                         e.name, cyc, act[7:4], act[3:2], act[1], act[0],
                         e.exp[7:4], e.exp[3:2], e.exp[1], e.exp[0]);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        bus_if.req  = 4'b0000;
        bus_if.done = 1'b0;

        // reset and idle
        step("reset", 0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        step("reset", 0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        for (int i = 0; i < 3; i++)
            step("idle", 1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

        // basic grant, done in 3rd owned cycle
        step("basic_grant", 1, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        step("basic_own",   1, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        step("basic_own",   1, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        step("basic_done",  1, 4'b0100, 1, 4'b0000, 2'd2, 0, 0);
        step("basic_idle",  1, 4'b0000, 0, 4'b0000, 2'd2, 0, 0);

        // non-owner req changes ignored; owner dropping req releases
        step("own2_grant",  1, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        step("nonowner",    1, 4'b1101, 0, 4'b0100, 2'd2, 1, 0);
        step("owner_drop",  1, 4'b1011, 0, 4'b0000, 2'd2, 0, 0);
        step("gap_idle",    1, 4'b0000, 0, 4'b0000, 2'd2, 0, 0);
        step("done_idle",   1, 4'b0000, 1, 4'b0000, 2'd2, 0, 0);

        // timeout: exactly 8 owned cycles, pulse, re-grant
        step("to_grant",    1, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);
        for (int i = 0; i < 7; i++)
            step("to_hold",  1, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);
        step("to_pulse",    1, 4'b0001, 0, 4'b0000, 2'd0, 0, 1);
        step("to_regrant",  1, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);
        step("to_release",  1, 4'b0001, 1, 4'b0000, 2'd0, 0, 0);

        // done in the 8th owned cycle: normal release, no pulse
        step("lim_grant",   1, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);
        for (int i = 0; i < 7; i++)
            step("lim_hold", 1, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);
        step("lim_done",    1, 4'b0001, 1, 4'b0000, 2'd0, 0, 0);
        step("lim_idle",    1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

        // reset in 3rd owned cycle
        step("mr_grant",    1, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
        step("mr_own",      1, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
        step("mr_own",      1, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
        step("mr_reset",    0, 4'b0010, 0, 4'b0000, 2'd0, 0, 0);
        step("mr_idle",     1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

`ifdef ARB4_ROUND_ROBIN_EN
        // rotating priority with all four requesting
        begin
            logic [3:0] g;
            for (int i = 0; i < 5; i++) begin
                g = 4'b0001 << (i % 4);
                step("rr_grant", 1, 4'b1111, 0, g,       2'(i % 4), 1, 0);
                step("rr_own",   1, 4'b1111, 0, g,       2'(i % 4), 1, 0);
                step("rr_done",  1, 4'b1111, 1, 4'b0000, 2'(i % 4), 0, 0);
            end
        end
`else
        // fixed priority: requester 1 always beats 3
        for (int i = 0; i < 3; i++) begin
            step("fp_grant", 1, 4'b1010, 0, 4'b0010, 2'd1, 1, 0);
            step("fp_own",   1, 4'b1010, 0, 4'b0010, 2'd1, 1, 0);
            step("fp_done",  1, 4'b1010, 1, 4'b0000, 2'd1, 0, 0);
        end
`endif
        step("end_idle", 1, 4'b0000, 0, 4'b0000, (`ifdef ARB4_ROUND_ROBIN_EN 2'd0 `else 2'd1 `endif), 0, 0);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() != 0; i++)
            @(posedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb4_grant_ctrl.md
Name: arb4_grant_ctrl

Overview:
- Four-requester arbiter/sequencer that shares one resource selected through a 2-to-4 one-hot select.
- Picks one requester, holds its one-hot grant until release or hold timeout, then inserts a one-cycle idle gap before re-arbitrating.
- Sits between requester logic and the shared resource's select lines; grant is registered and glitch-free.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles per ownership; 0 = unlimited.
- CNT_W, 4, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- req  input  4  request vector; req[i] is level request from requester i.
- done  input  1  current owner releases the resource; effective only in OWN.
- grant  output  4  one-hot grant, registered; all zero when not owning.
- grant_idx  output  2  binary index of current or most recent owner.
- busy  output  1  high while in OWN.
- timeout  output  1  one-cycle pulse when an ownership is force-released by MAX_HOLD.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values, applied on any rising clk with rst_n=0, including mid-ownership:
  - state=IDLE, grant=0000, grant_idx=00, busy=0, timeout=0, hold_cnt=0, last_idx=11.
- Output encoding:
  - grant = decode2to4(grant_idx) when busy, else 0000.
  - All outputs are registered; no combinational path from req or done to outputs.
- State IDLE:
  - Outputs: grant=0000, busy=0.
  - If req!=0000 at the edge: select winner w, load grant_idx=w, hold_cnt=1, last_idx=w, go to OWN.
  - Latency: request sampled in cycle N, grant visible in cycle N+1.
  - If req=0000: stay in IDLE.
- State OWN, evaluated at each edge in priority order:
  1. done=1 or req[grant_idx]=0: go to IDLE. timeout=0.
  2. MAX_HOLD!=0 and hold_cnt==MAX_HOLD: go to IDLE and pulse timeout=1 for exactly the following cycle.
  3. Otherwise: hold_cnt++ and stay in OWN.
- Timing guarantees:
  - A grant lasts at most MAX_HOLD cycles.
  - Handover always includes one IDLE cycle with grant=0000, so grants to different requesters never touch.
- Simultaneous events:
  - done coincident with the hold limit counts as a normal release; no timeout pulse.
  - Changes on non-owner req bits during OWN are ignored.
  - done while in IDLE is ignored.
- grant_idx retains the last owner while in IDLE.
- hold_cnt saturates logically; it never wraps, because the forced release happens first.

Optional Feature:
- Macro: ARB4_ROUND_ROBIN_EN.
- Defined: rotating priority.
  - Search order starts at (last_idx+1) mod 4 and wraps; 3 wraps to 0.
  - After reset last_idx=3, so the first search starts at requester 0.
  - A requester that just released or timed out becomes lowest priority.
- Undefined: fixed priority, req[0] highest, then 1, 2, 3.
  - last_idx is still maintained but unused for selection.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, then req=0000 → grant=0000, busy=0, grant_idx=00, timeout=0 every cycle.
- Basic grant: req=0100 at cycle N → grant=0100 and grant_idx=10 at N+1; done=1 at N+3 → grant=0000 at N+4.
- Fixed priority (macro undefined): req=1010 held steady, each owner releases with done after 2 cycles → grants always 0010, each separated by one 0000 cycle.
- Round robin (macro defined): req=1111 held, done each 2nd owned cycle → grant sequence 0001, 0010, 0100, 1000, 0001, with a 0000 cycle between each.
- Timeout: MAX_HOLD=8, req=0001 held, done=0 → grant=0001 for exactly 8 cycles, then grant=0000 with timeout=1 for 1 cycle, then re-grant 0001.
- Reset mid-operation / simultaneous events:
  - rst_n=0 during the 3rd owned cycle → grant=0000 at the next edge.
  - Separately, done=1 in the 8th owned cycle → release with timeout=0.
